alu_ex_stage: RTL

- Two-stage integer execute pipeline feeding the 32-bit adder/subtractor and consuming its result.
- Stage 1 registers the decoded operands and op, and drives the adder's mode and operands.
- Stage 2 registers the final ALU result (add/sub/compare/logic) for writeback.
- Sits between decode/issue and writeback; valid/ready handshake on both sides, plus a flush input for branch redirect.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/int_add_sub.sv | 17 +
 rtl/alu_ex_stage.sv | 116 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the integer execute stage: datapath width,
// ALU op encoding and the op-to-adder-mode mapping.
package alu_pkg;

    localparam int XLEN = 32;
    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] ALU_ADD    = 4'd0;
    localparam logic [OP_W-1:0] ALU_SUB    = 4'd1;
    localparam logic [OP_W-1:0] ALU_SLT    = 4'd2;
    localparam logic [OP_W-1:0] ALU_SLTU   = 4'd3;
    localparam logic [OP_W-1:0] ALU_XOR    = 4'd4;
    localparam logic [OP_W-1:0] ALU_OR     = 4'd5;
    localparam logic [OP_W-1:0] ALU_AND    = 4'd6;
    localparam logic [OP_W-1:0] ALU_PASS_B = 4'd7;

    // Compares are computed from A-B, so they share the subtract mode.
    function automatic logic adder_mode(input logic [OP_W-1:0] op);
        return (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
    endfunction

endpackage

// File: rtl/int_add_sub.sv
// 32-bit integer adder/subtractor: mode 0 adds, mode 1 subtracts.
// Results wrap modulo 2^W; no carry or overflow is exported.
module int_add_sub #(
    parameter int W = 32
) (
    input  logic         i_mode,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum
);

    // Single adder: subtraction is a + ~b + 1.
    always_comb begin
        o_sum = i_a + (i_b ^ {W{i_mode}}) + {{(W-1){1'b0}}, i_mode};
    end

endmodule

// File: rtl/alu_ex_stage.sv
// Two-stage integer execute pipeline. Stage 1 holds decoded operands and
// drives the shared adder; stage 2 holds the finished result for writeback.
// Valid/ready on both sides, flush drops everything in flight.
module alu_ex_stage #(
    parameter int XLEN = alu_pkg::XLEN,
    parameter int RD_W = 5
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [3:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [XLEN-1:0] i_imm,
    input  logic            i_use_imm,
    input  logic [RD_W-1:0] i_rd,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic [RD_W-1:0] o_rd
);

    import alu_pkg::*;

    logic            vld_p1;
    logic [3:0]      op_p1;
    logic [XLEN-1:0] a_p1;
    logic [XLEN-1:0] b_p1;
    logic [RD_W-1:0] rd_p1;

    logic            s1_en;
    logic            s2_en;
    logic            mode_p1;
    logic [XLEN-1:0] sum_p1;
    logic            lt_p1;
    logic            ltu_p1;
    logic [XLEN-1:0] res_p1;

    // Pipeline advance enables; o_ready sees i_ready combinationally.
    always_comb begin
        s2_en   = !o_valid || i_ready;
        s1_en   = !vld_p1 || s2_en;
        o_ready = s1_en && !i_flush;
    end

    // ---- stage 1: operand capture ----
    // Stage-1 valid and operands; flush overrides the enable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p1 <= 1'b0;
            op_p1  <= '0;
            a_p1   <= '0;
            b_p1   <= '0;
            rd_p1  <= '0;
        end else if (i_flush) begin
            vld_p1 <= 1'b0;
        end else if (s1_en) begin
            vld_p1 <= i_valid;
            op_p1  <= i_op;
            a_p1   <= i_rs1;
            b_p1   <= i_use_imm ? i_imm : i_rs2;
            rd_p1  <= i_rd;
        end
    end

    // Adder mode follows the registered op.
    always_comb begin
        mode_p1 = adder_mode(op_p1);
    end

    int_add_sub #(
        .W (XLEN)
    ) u_add_sub (
        .i_mode (mode_p1),
        .i_a    (a_p1),
        .i_b    (b_p1),
        .o_sum  (sum_p1)
    );

    // Result select; compares use the difference sign unless operand
    // signs differ, where the answer is fixed by the sign bits alone.
    always_comb begin
        lt_p1  = (a_p1[XLEN-1] ^ b_p1[XLEN-1]) ? a_p1[XLEN-1] : sum_p1[XLEN-1];
        ltu_p1 = (a_p1[XLEN-1] ^ b_p1[XLEN-1]) ? b_p1[XLEN-1] : sum_p1[XLEN-1];
        res_p1 = '0;
        case (op_p1)
            ALU_ADD, ALU_SUB: res_p1 = sum_p1;
            ALU_SLT:          res_p1 = {{(XLEN-1){1'b0}}, lt_p1};
            ALU_SLTU:         res_p1 = {{(XLEN-1){1'b0}}, ltu_p1};
            ALU_XOR:          res_p1 = a_p1 ^ b_p1;
            ALU_OR:           res_p1 = a_p1 | b_p1;
            ALU_AND:          res_p1 = a_p1 & b_p1;
            ALU_PASS_B:       res_p1 = b_p1;
            default:          res_p1 = '0;
        endcase
    end

    // ---- stage 2: writeback result ----
    // Output register holds steady while downstream stalls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid  <= 1'b0;
            o_result <= '0;
            o_rd     <= '0;
        end else if (i_flush) begin
            o_valid  <= 1'b0;
        end else if (s2_en) begin
            o_valid  <= vld_p1;
            o_result <= res_p1;
            o_rd     <= rd_p1;
        end
    end

endmodule
